// File: rtl/rf_pkg.sv
// Shared types and default parameter values for the integer register file.
package rf_pkg;

  typedef enum logic {
    SWEEP,
    READY
  } rf_state_e;

  localparam int          XLEN_D      = 32;
  localparam int          NREG_D      = 32;
  localparam logic [31:0] SP_INIT_D   = 32'h2ffc;
  localparam int          HALT_REG_D  = 17;
  localparam int          HALT_CODE_D = 10;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: x0 forces zero, optional same-cycle write forwarding.
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            enable,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            write_enable,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_din,
  output logic [XLEN-1:0] dout
);

  // NOTE: every path assigns dout after a default, so no latch is inferred.
  always_comb begin
    dout = '0;
    if (enable && addr != '0) begin
      if (BYPASS && write_enable && rd == addr) dout = rd_din;
      else                                      dout = rf_data;
    end
  end

endmodule

// File: rtl/param_register_file.sv
// Parametrised integer register file with reset sweep, write->read bypass and ecall halt flag.
module param_register_file
  import rf_pkg::*;
#(
  parameter int              XLEN      = XLEN_D,
  parameter int              NREG      = NREG_D,
  parameter int              NRD       = 2,
  parameter bit              BYPASS    = 1'b1,
  parameter int              SP_IDX    = 2,
  parameter logic [XLEN-1:0] SP_INIT   = XLEN'(SP_INIT_D),
  parameter int              HALT_REG  = HALT_REG_D,
  parameter int              HALT_CODE = HALT_CODE_D,
  localparam int             AW        = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_dout,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     rd_din,
  input  logic                write_enable,
  input  logic                is_ecall,
  output logic                is_halted,
  output logic                init_busy
);

  localparam logic [AW-1:0] HALT_ADDR = AW'(HALT_REG);

  rf_state_e       state, state_next;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] rf [NREG];
  logic            ready;
  logic            wr_ok;
  logic            sweep_last;
  logic [XLEN-1:0] halt_val;

  assign ready      = (state == READY);
  assign wr_ok      = ready && write_enable;
  assign sweep_last = (cnt == AW'(NREG - 1));
  assign init_busy  = !ready;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state <= SWEEP;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SWEEP: if (sweep_last) state_next = READY;
      READY: state_next = READY;
    endcase
  end

  // Counter parks at NREG-1 instead of wrapping; reset restarts it.
  always_ff @(posedge clk) begin
    if (reset)                        cnt <= '0;
    else if (!ready && !sweep_last)   cnt <= cnt + 1'b1;
  end

  // NOTE: the storage array has no reset branch; the post-reset sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready)                   rf[cnt] <= (cnt == AW'(SP_IDX)) ? SP_INIT : '0;
      else if (wr_ok && rd != '0)   rf[rd]  <= rd_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                                is_halted <= 1'b0;
    else if (ready && is_ecall && halt_val == XLEN'(HALT_CODE)) is_halted <= 1'b1;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rs_addr[k*AW +: AW];

    rf_read_port #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .enable       (ready),
      .addr         (addr),
      .rf_data      (rf[addr]),
      .write_enable (wr_ok),
      .rd           (rd),
      .rd_din       (rd_din),
      .dout         (rs_dout[k*XLEN +: XLEN])
    );
  end

  // Halt inspection sees exactly what a normal read of HALT_REG would return.
  rf_read_port #(
    .XLEN   (XLEN),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_halt_port (
    .enable       (ready),
    .addr         (HALT_ADDR),
    .rf_data      (rf[HALT_ADDR]),
    .write_enable (wr_ok),
    .rd           (rd),
    .rd_din       (rd_din),
    .dout         (halt_val)
  );

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file driven from shared stimulus.
module tb_param_register_file;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rs_addr;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     rd_din;
  logic                write_enable;
  logic                is_ecall;
  logic [NRD*XLEN-1:0] dout_b, dout_n;
  logic                halted_b, halted_n;
  logic                busy_b, busy_n;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  param_register_file #(.BYPASS(1'b1)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .rs_addr      (rs_addr),
    .rs_dout      (dout_b),
    .rd           (rd),
    .rd_din       (rd_din),
    .write_enable (write_enable),
    .is_ecall     (is_ecall),
    .is_halted    (halted_b),
    .init_busy    (busy_b)
  );

  param_register_file #(.BYPASS(1'b0)) u_dut_n (
    .clk          (clk),
    .reset        (reset),
    .rs_addr      (rs_addr),
    .rs_dout      (dout_n),
    .rd           (rd),
    .rd_din       (rd_din),
    .write_enable (write_enable),
    .is_ecall     (is_ecall),
    .is_halted    (halted_n),
    .init_busy    (busy_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] din;
    logic        ecall;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0_b;
    logic [31:0] e1_b;
    logic [31:0] e0_n;
    logic [31:0] e1_n;
    logic        h_b;
    logic        h_n;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with init_busy high, starting right after reset release.
  task automatic sweep_and_count(input string tag);
    int nb = 0;
    int nn = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_b) nb++;
      if (busy_n) nn++;
      if (!busy_b && !busy_n) break;
      tick();
    end
    check({tag, "_busy_cycles_b"}, 32'(nb), 32'd32);
    check({tag, "_busy_cycles_n"}, 32'(nn), 32'd32);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd2,  5'd5,  32'h2ffc,     32'h0,    32'h2ffc, 32'h0,    1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd7,  5'd2,  32'hDEADBEEF, 32'h2ffc, 32'h0,    32'h2ffc, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,    32'h0,    32'h0,    1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd17, 32'd10,       1'b1, 5'd17, 5'd2,  32'd10,       32'h2ffc, 32'h0,    32'h2ffc, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd17, 5'd17, 32'd10,       32'd10,   32'd10,   32'd10,   1'b1, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd17, 5'd0,  32'd10,       32'h0,    32'd10,   32'h0,    1'b1, 1'b1};
    vecs[8] = '{1'b1, 5'd9,  32'h1234,     1'b0, 5'd9,  5'd17, 32'h1234,     32'd10,   32'h0,    32'd10,   1'b1, 1'b1};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  5'd9,  32'h1234,     32'h1234, 32'h1234, 32'h1234, 1'b1, 1'b1};

    reset = 1'b1; write_enable = 1'b0; is_ecall = 1'b0;
    rd = '0; rd_din = '0; rs_addr = '0;

    // Reset held three cycles.
    tick();
    check("rst_busy_b",   32'(busy_b),   32'd1);
    check("rst_halted_b", 32'(halted_b), 32'd0);
    check("rst_halted_n", 32'(halted_n), 32'd0);
    check("rst_dout_b",   dout_b[31:0],  32'h0);
    tick();
    tick();

    // Release; a write to x5 and an ecall during the sweep must both be ignored.
    reset = 1'b0;
    write_enable = 1'b1; rd = 5'd5; rd_din = 32'h55; is_ecall = 1'b1;
    rs_addr = {5'd5, 5'd2};
    #1;
    check("sweep_dout0_b", dout_b[31:0],  32'h0);
    check("sweep_dout1_b", dout_b[63:32], 32'h0);
    sweep_and_count("init");
    write_enable = 1'b0; is_ecall = 1'b0;
    check("post_sweep_halted_b", 32'(halted_b), 32'd0);

    for (int i = 0; i < 10; i++) begin
      write_enable = vecs[i].we;
      rd           = vecs[i].rd;
      rd_din       = vecs[i].din;
      is_ecall     = vecs[i].ecall;
      rs_addr      = {vecs[i].a1, vecs[i].a0};
      #1;
      check($sformatf("v%0d_p0_b", i), dout_b[31:0],  vecs[i].e0_b);
      check($sformatf("v%0d_p1_b", i), dout_b[63:32], vecs[i].e1_b);
      check($sformatf("v%0d_p0_n", i), dout_n[31:0],  vecs[i].e0_n);
      check($sformatf("v%0d_p1_n", i), dout_n[63:32], vecs[i].e1_n);
      tick();
      check($sformatf("v%0d_halt_b", i), 32'(halted_b), 32'(vecs[i].h_b));
      check($sformatf("v%0d_halt_n", i), 32'(halted_n), 32'(vecs[i].h_n));
    end
    write_enable = 1'b0; is_ecall = 1'b0;

    // Reset while halted clears the flag.
    reset = 1'b1;
    tick();
    check("rehalt_clr_b", 32'(halted_b), 32'd0);
    check("rehalt_clr_n", 32'(halted_n), 32'd0);
    check("rehalt_busy_b", 32'(busy_b), 32'd1);

    // Reset again ten cycles into the sweep; the full sweep restarts.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midsweep_busy_b", 32'(busy_b), 32'd1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sweep_and_count("restart");

    rs_addr = {5'd7, 5'd2};
    #1;
    check("restart_x2_b", dout_b[31:0],  32'h2ffc);
    check("restart_x7_b", dout_b[63:32], 32'h0);
    check("restart_x7_n", dout_n[63:32], 32'h0);

    // x17 = 9 followed by ecall must not halt.
    write_enable = 1'b1; rd = 5'd17; rd_din = 32'd9;
    tick();
    write_enable = 1'b0; is_ecall = 1'b1; rs_addr = {5'd17, 5'd17};
    #1;
    check("x17_nine_b", dout_b[31:0], 32'd9);
    check("x17_nine_n", dout_n[63:32], 32'd9);
    tick();
    check("nohalt9_b", 32'(halted_b), 32'd0);
    check("nohalt9_n", 32'(halted_n), 32'd0);
    tick();
    is_ecall = 1'b0;
    check("nohalt9_late_b", 32'(halted_b), 32'd0);
    check("nohalt9_late_n", 32'(halted_n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
